// File: rtl/master_bridge_async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// master_bridge_async_fifo_pkg
// Shared definitions for the master bridge async FIFO pointer blocks.
//   ADDR_WIDTH_DEF : default FIFO address width (depth = 2**ADDR_WIDTH_DEF)
//   FUNC_W         : working width of the Gray helper functions; callers
//                    zero-extend their pointer and cast the result back down
//   bin2gray       : binary -> reflected Gray code
//   gray2bin       : reflected Gray code -> binary (zero-extended input)
// -----------------------------------------------------------------------------
package master_bridge_async_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int FUNC_W         = 32;

  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] bin);
    return bin ^ {1'b0, bin[FUNC_W-1:1]};
  endfunction

  // Zero-extended upper bits keep the prefix XOR neutral, so narrow
  // pointers convert correctly through the wide helper.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] gray);
    logic [FUNC_W-1:0] bin;
    bin = gray;
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/master_bridge_async_fifo_wr_ptr_full_if.sv
// -----------------------------------------------------------------------------
// master_bridge_async_fifo_wr_ptr_full_if
// Bundle between the write-side client / read-domain synchronizer and the
// write pointer + flag block.
//   WR_EN            : push request from the write client
//   RD_PTR_GRAY_SYNC : read pointer, Gray, already synchronized into CLK
//   WR_ADDR          : memory write address
//   WR_PUSH          : memory write strobe
//   WR_PTR_GRAY      : registered Gray write pointer toward the read domain
//   WR_FULL/WR_AFULL : registered full / almost-full flags
//   WR_LEVEL         : registered write-side fill level
//   WR_OVFL          : sticky overflow error
// Modports: master = pointer block side, slave = client/environment side.
// -----------------------------------------------------------------------------
interface master_bridge_async_fifo_wr_ptr_full_if
  import master_bridge_async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  WR_EN;
  logic [ADDR_WIDTH:0]   RD_PTR_GRAY_SYNC;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic                  WR_PUSH;
  logic [ADDR_WIDTH:0]   WR_PTR_GRAY;
  logic                  WR_FULL;
  logic                  WR_AFULL;
  logic [ADDR_WIDTH:0]   WR_LEVEL;
  logic                  WR_OVFL;

  modport master (
    input  WR_EN,
    input  RD_PTR_GRAY_SYNC,
    output WR_ADDR,
    output WR_PUSH,
    output WR_PTR_GRAY,
    output WR_FULL,
    output WR_AFULL,
    output WR_LEVEL,
    output WR_OVFL
  );

  modport slave (
    output WR_EN,
    output RD_PTR_GRAY_SYNC,
    input  WR_ADDR,
    input  WR_PUSH,
    input  WR_PTR_GRAY,
    input  WR_FULL,
    input  WR_AFULL,
    input  WR_LEVEL,
    input  WR_OVFL
  );

endinterface

// File: rtl/master_bridge_async_fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// master_bridge_async_fifo_gray2bin
// Combinational Gray -> binary converter (XOR prefix from the MSB down).
// Shared by the write-side and read-side pointer blocks.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary output, WIDTH bits
// -----------------------------------------------------------------------------
module master_bridge_async_fifo_gray2bin
  import master_bridge_async_fifo_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH_DEF + 1
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it; written
  // per bit so there is no chained self-reference inside one process.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign bin[g] = ^gray[WIDTH-1:g];
  end

endmodule

// File: rtl/master_bridge_async_fifo_wr_ptr_full.sv
// -----------------------------------------------------------------------------
// master_bridge_async_fifo_wr_ptr_full
// Write-domain pointer and flag generator of the master bridge async FIFO.
// Holds the binary write pointer, publishes a registered Gray copy for the
// read domain and derives full / almost-full / level / overflow from the
// synchronized Gray read pointer.
//   CLK  : write-domain clock
//   RST  : synchronous active-low reset
//   bus  : master modport (WR_EN, RD_PTR_GRAY_SYNC in; WR_ADDR, WR_PUSH,
//          WR_PTR_GRAY, WR_FULL, WR_AFULL, WR_LEVEL, WR_OVFL out)
// -----------------------------------------------------------------------------
module master_bridge_async_fifo_wr_ptr_full
  import master_bridge_async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic CLK,
  input  logic RST,
  master_bridge_async_fifo_wr_ptr_full_if.master bus
);

  localparam int            PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wgray_r;
  logic [PW-1:0] level_r;
  logic          full_r;
  logic          afull_r;
  logic          ovfl_r;

  logic          accept_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_sync_s;
  logic [PW-1:0] level_next_s;
  logic [PW-1:0] full_cmp_s;

  master_bridge_async_fifo_gray2bin #(
    .WIDTH (PW)
  ) u_rd_gray2bin (
    .gray (bus.RD_PTR_GRAY_SYNC),
    .bin  (rbin_sync_s)
  );

  // Next pointer, its Gray image, the level and the full-compare pattern.
  always_comb begin
    accept_s     = bus.WR_EN & ~full_r;
    wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, accept_s};
    wgray_next_s = PW'(bin2gray(FUNC_W'(wbin_next_s)));
    level_next_s = wbin_next_s - rbin_sync_s;
    // Full in Gray space: write pointer is one lap ahead of the read pointer,
    // which inverts the two MSBs of the Gray code and leaves the rest equal.
    full_cmp_s   = {~bus.RD_PTR_GRAY_SYNC[PW-1:PW-2], bus.RD_PTR_GRAY_SYNC[PW-3:0]};
  end

  // Pointer and flag registers; reset takes priority over any push.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wbin_r  <= '0;
      wgray_r <= '0;
      level_r <= '0;
      full_r  <= 1'b0;
      afull_r <= 1'b0;
      ovfl_r  <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      // Registered straight from the Gray image so the crossing sees a
      // single-bit, glitch-free step per accepted push.
      wgray_r <= wgray_next_s;
      level_r <= level_next_s;
      full_r  <= (wgray_next_s == full_cmp_s);
      afull_r <= (level_next_s >= AFULL_C);
      ovfl_r  <= ovfl_r | (bus.WR_EN & full_r);
    end
  end

  assign bus.WR_ADDR     = wbin_r[ADDR_WIDTH-1:0];
  assign bus.WR_PUSH     = accept_s;
  assign bus.WR_PTR_GRAY = wgray_r;
  assign bus.WR_FULL     = full_r;
  assign bus.WR_AFULL    = afull_r;
  assign bus.WR_LEVEL    = level_r;
  assign bus.WR_OVFL     = ovfl_r;

endmodule

// File: tb/tb_master_bridge_async_fifo_wr_ptr_full.sv
// -----------------------------------------------------------------------------
// tb_master_bridge_async_fifo_wr_ptr_full
// Directed bench: the driver applies one cycle of stimulus at each falling
// edge and queues the expected post-edge outputs; the monitor samples the
// combinational strobe before the rising edge, the registers just after it,
// and compares against the queued entry.
// -----------------------------------------------------------------------------
module tb_master_bridge_async_fifo_wr_ptr_full;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  master_bridge_async_fifo_wr_ptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  master_bridge_async_fifo_wr_ptr_full #(
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (12)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic          is_rst;
    logic          chk_push;
    logic          exp_push;
    logic [AW-1:0] exp_pre_addr;
    logic [AW-1:0] exp_addr;
    logic [PW-1:0] exp_gray;
    logic          exp_full;
    logic          exp_afull;
    logic [PW-1:0] exp_level;
    logic          exp_ovfl;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state of the write side.
  logic [PW-1:0] wbin_m  = '0;
  logic          full_m  = 1'b0;
  logic          afull_m = 1'b0;
  logic [PW-1:0] level_m = '0;
  logic          ovfl_m  = 1'b0;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, advance the model, queue expectations.
  task automatic step(input logic rst, input logic en, input logic [PW-1:0] rgray);
    exp_t          e;
    logic [PW-1:0] lvl;
    @(negedge CLK);
    RST                  = rst;
    bus.WR_EN            = en;
    bus.RD_PTR_GRAY_SYNC = rgray;
    e.is_rst       = ~rst;
    e.chk_push     = rst;
    e.exp_push     = en & ~full_m;
    e.exp_pre_addr = wbin_m[AW-1:0];
    if (!rst) begin
      wbin_m  = '0;
      full_m  = 1'b0;
      afull_m = 1'b0;
      level_m = '0;
      ovfl_m  = 1'b0;
    end else begin
      if (en && full_m) ovfl_m = 1'b1;
      if (en && !full_m) wbin_m = wbin_m + 5'd1;
      lvl     = wbin_m - g2b(rgray);
      full_m  = (lvl == 5'd16);
      afull_m = (lvl >= 5'd12);
      level_m = lvl;
    end
    e.exp_addr  = wbin_m[AW-1:0];
    e.exp_gray  = b2g(wbin_m);
    e.exp_full  = full_m;
    e.exp_afull = afull_m;
    e.exp_level = level_m;
    e.exp_ovfl  = ovfl_m;
    q.push_back(e);
  endtask

  // Monitor: strobe/address before the edge, registers after it.
  initial begin
    logic          push_pre;
    logic [AW-1:0] addr_pre;
    logic [PW-1:0] prev_gray;
    exp_t          e;
    prev_gray = '0;
    forever begin
      @(negedge CLK);
      #2;
      push_pre = bus.WR_PUSH;
      addr_pre = bus.WR_ADDR;
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_push) begin
          cmp("wr_push", 32'(push_pre), 32'(e.exp_push));
          if (e.exp_push) cmp("write_addr", 32'(addr_pre), 32'(e.exp_pre_addr));
        end
        cmp("wr_addr",  32'(bus.WR_ADDR),     32'(e.exp_addr));
        cmp("wr_gray",  32'(bus.WR_PTR_GRAY), 32'(e.exp_gray));
        cmp("wr_full",  32'(bus.WR_FULL),     32'(e.exp_full));
        cmp("wr_afull", 32'(bus.WR_AFULL),    32'(e.exp_afull));
        cmp("wr_level", 32'(bus.WR_LEVEL),    32'(e.exp_level));
        cmp("wr_ovfl",  32'(bus.WR_OVFL),     32'(e.exp_ovfl));
        if (!e.is_rst) begin
          cmp("gray_hamming", 32'($countones(prev_gray ^ bus.WR_PTR_GRAY) <= 1), 32'd1);
        end
        prev_gray = bus.WR_PTR_GRAY;
      end
    end
  end

  // Directed sequence.
  initial begin
    logic [PW-1:0] rg;
    bus.WR_EN            = 1'b0;
    bus.RD_PTR_GRAY_SYNC = '0;

    // Reset held with a push request pending.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'b00000);
    step(1'b1, 1'b0, 5'b00000);

    // Fill to 16 entries with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 5'b00000);
    @(posedge CLK); #1;
    cmp("fill_gray_const",  32'(bus.WR_PTR_GRAY), 32'h18);
    cmp("fill_level_const", 32'(bus.WR_LEVEL),    32'd16);
    cmp("fill_full_const",  32'(bus.WR_FULL),     32'd1);

    // Overflow attempts while full.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 5'b00000);

    // Read pointer advances to 1: full drops, level 15; one push refills.
    step(1'b1, 1'b0, 5'b00001);
    @(posedge CLK); #1;
    cmp("drain_full_const",  32'(bus.WR_FULL),  32'd0);
    cmp("drain_level_const", 32'(bus.WR_LEVEL), 32'd15);
    step(1'b1, 1'b1, 5'b00001);

    // Read pointer to 8 -> level 9, then reset mid-operation.
    step(1'b1, 1'b0, 5'b01100);
    @(posedge CLK); #1;
    cmp("mid_level_const", 32'(bus.WR_LEVEL), 32'd9);
    cmp("mid_ovfl_const",  32'(bus.WR_OVFL),  32'd1);
    step(1'b0, 1'b1, 5'b00000);
    @(posedge CLK); #1;
    cmp("rst_level_const", 32'(bus.WR_LEVEL), 32'd0);
    cmp("rst_ovfl_const",  32'(bus.WR_OVFL),  32'd0);

    // Two pushes to reach level 2, then read follows write at distance 2.
    step(1'b1, 1'b1, 5'b00000);
    step(1'b1, 1'b1, 5'b00000);
    for (int i = 0; i < 40; i++) begin
      rg = b2g(wbin_m - 5'd1);
      step(1'b1, 1'b1, rg);
    end
    @(posedge CLK); #1;
    cmp("wrap_level_const", 32'(bus.WR_LEVEL),    32'd2);
    cmp("wrap_gray_const",  32'(bus.WR_PTR_GRAY), 32'(b2g(5'd10)));
    step(1'b1, 1'b0, rg);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_queue actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_bridge_async_fifo_wr_ptr_full.md
Name: master_bridge_async_fifo_wr_ptr_full

Overview:
- Write-domain pointer and flag generator for the master bridge async FIFO.
- Tracks the binary write pointer and drives the memory write address.
- Publishes a registered Gray-coded write pointer for the read-domain synchronizer.
- Consumes the read pointer after it has been Gray-encoded and synchronized into this domain, and from it derives full, almost-full, fill level and a sticky overflow error.
- This is the source end of the pointer crossing; the read domain's multi-stage bit synchronizer is the receiving end.

Parameters:
- ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits wide.
- AFULL_THRESH, 12, level at or above which WR_AFULL asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- CLK  input  1  write-domain clock.
- RST  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- WR_EN  input  1  push request from the write-side client.
- RD_PTR_GRAY_SYNC  input  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronized into CLK.
- WR_ADDR  output  ADDR_WIDTH  memory write address (low bits of the binary write pointer).
- WR_PUSH  output  1  memory write strobe; equals WR_EN & ~WR_FULL (combinational).
- WR_PTR_GRAY  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- WR_FULL  output  1  registered full flag.
- WR_AFULL  output  1  registered almost-full flag.
- WR_LEVEL  output  ADDR_WIDTH+1  registered fill level as seen by the write side, 0..2**ADDR_WIDTH.
- WR_OVFL  output  1  sticky overflow error.

Behaviour:
- Reset (RST=0 at a CLK edge) clears all registers:
  - binary pointer = 0, so WR_ADDR = 0
  - WR_PTR_GRAY = 0, WR_FULL = 0, WR_AFULL = 0, WR_LEVEL = 0, WR_OVFL = 0.
  - Reset wins over any simultaneous WR_EN.
  - Reset mid-operation discards all state; the read domain is reset together with this block.
- Accept rule: a push is accepted when WR_EN=1 and WR_FULL=1 is not asserted (WR_FULL=0).
  - The write data is written at the current WR_ADDR in that same cycle.
  - The binary pointer becomes wbin+1 on the next edge.
  - Pointer arithmetic is modulo 2**(ADDR_WIDTH+1); wrap-around is natural and the MSB toggles on each wrap.
- Next-state values, computed combinationally:
  - wbin_next = wbin + accept.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - rbin_sync = Gray-to-binary of RD_PTR_GRAY_SYNC.
- WR_PTR_GRAY is registered from wgray_next.
  - It changes by at most one bit per cycle and never glitches, which is a hard requirement of the crossing.
  - It never passes through combinational logic before the read-domain synchronizer.
- Full:
  - WR_FULL <= (wgray_next == {~RD_PTR_GRAY_SYNC[A:A-1], RD_PTR_GRAY_SYNC[A-2:0]}), where A = ADDR_WIDTH.
  - Full asserts on the same edge that stores the 2**ADDR_WIDTH-th entry.
- Level: WR_LEVEL <= wbin_next - rbin_sync, taken modulo 2**(A+1).
- Almost-full: WR_AFULL <= (wbin_next - rbin_sync) >= AFULL_THRESH.
- Pessimism: the synchronized read pointer lags the true read pointer. Full, almost-full and level may therefore report more occupancy than is real, but never less. Full deasserts no earlier than the edge after RD_PTR_GRAY_SYNC advances.
- Overflow:
  - WR_EN=1 while WR_FULL=1 is dropped: no pointer change, WR_PUSH=0.
  - WR_OVFL is set on the next edge and stays set until reset.
- Simultaneous events: an accepted push in the same cycle as a read-pointer advance updates both sides of the comparison in one step. The level can be unchanged, but the Gray output still steps by one.
- Latency:
  - WR_PTR_GRAY, WR_FULL, WR_AFULL and WR_LEVEL change 1 cycle after an accepted push.
  - Read-pointer changes show up 1 cycle after RD_PTR_GRAY_SYNC changes.

Decomposition:
- Shared package master_bridge_async_fifo_pkg holds:
  - the FIFO ADDR_WIDTH default
  - the bin2gray and gray2bin functions, also reused by the read-side pointer block.
- One natural sub-module: master_bridge_async_fifo_gray2bin, a combinational XOR prefix of width ADDR_WIDTH+1. It is instantiated once here and once on the read side.
- All other logic is flat in this block.

Test Plan:
- Reset: RST=0 for 3 cycles with WR_EN=1 -> all outputs 0; no pointer advance; WR_PUSH may pulse combinationally, but no state changes.
- Fill: RD_PTR_GRAY_SYNC=0, WR_EN=1 for 16 cycles (ADDR_WIDTH=4) -> WR_ADDR steps 0..15; WR_AFULL asserts after the 12th push; WR_FULL=1 and WR_LEVEL=16 after the 16th; WR_PTR_GRAY=5'b11000.
- Overflow: from full, WR_EN=1 for 2 cycles -> WR_PUSH=0; WR_ADDR holds 0; WR_OVFL=1 and sticky after later pushes and drains.
- Drain: from full, set RD_PTR_GRAY_SYNC=5'b00001 (read binary 1) -> one cycle later WR_FULL=0 and WR_LEVEL=15; next push writes address 0 and WR_FULL=1 again.
- Wrap/Gray: with the read pointer tracking the write pointer minus 2, push 40 times -> each WR_PTR_GRAY transition has Hamming distance 1; the pointer passes 31->0; WR_LEVEL stays 2.
- Reset mid-operation: at level 9, RST=0 for one edge -> all outputs 0 on that edge; the first push after reset writes address 0.
